// File: rtl/plant_input_conditioner_pkg.sv
// Shared constants for the plant input conditioner: default channel count,
// debounce timing and the event direction encoding.
package plant_input_conditioner_pkg;

  localparam int NCH_DEF          = 8;
  localparam int CNT_W_DEF        = 16;
  localparam int DEBOUNCE_CYC_DEF = 1000;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

endpackage

// File: rtl/plant_input_conditioner_debounce_ch.sv
// One sensor channel: two-flop synchronizer, debounce counter, stable level
// and a single-cycle strobe with direction whenever the level flips.
module plant_debounce_ch
  import plant_input_conditioner_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sense_i,
  output logic level_o,
  output logic strobe_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    hit     = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      hit     = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o  = level_q;
  assign strobe_o = hit;
  assign rise_o   = sync2_q ? EVT_RISE : EVT_FALL;

endmodule

// File: rtl/plant_input_conditioner.sv
// Debounces NCH raw sensor inputs and turns level changes into a stream of
// (channel, direction) events drained one per valid/ready handshake.
module plant_input_conditioner
  import plant_input_conditioner_pkg::*;
#(
  parameter int NCH          = NCH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int IDX_W        = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NCH-1:0]   sense_i,
  input  logic             enable_i,
  output logic [NCH-1:0]   level_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_chan_o,
  output logic             evt_rise_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i
);

  logic [NCH-1:0]   strobe, rise;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   pend_rise_q, pend_rise_d;
  logic [NCH-1:0]   take_oh;
  logic             evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0] evt_chan_q, evt_chan_d;
  logic             evt_rise_q, evt_rise_d;
  logic             ovf_q, ovf_d, ovf_set;
  logic             load, sel_vld;
  logic [IDX_W-1:0] sel_idx;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    plant_debounce_ch #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ch (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .sense_i  (sense_i[g]),
      .level_o  (level_o[g]),
      .strobe_o (strobe[g]),
      .rise_o   (rise[g])
    );
  end

  assign load = !evt_valid_q || evt_ready_i;

  // Lowest index wins; selection looks only at registered pend so a fresh
  // strobe is never forwarded in the cycle it arrives.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i] && enable_i) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    take_oh = '0;
    if (load && sel_vld) take_oh[sel_idx] = 1'b1;
  end

  always_comb begin
    pend_d      = pend_q;
    pend_rise_d = pend_rise_q;
    ovf_set     = 1'b0;
    if (!enable_i) begin
      pend_d = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (take_oh[i]) pend_d[i] = 1'b0;
        if (strobe[i]) begin
          if (pend_q[i] && !take_oh[i]) ovf_set = 1'b1;
          pend_d[i]      = 1'b1;
          pend_rise_d[i] = rise[i];
        end
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    evt_rise_d  = evt_rise_q;
    if (load) begin
      evt_valid_d = sel_vld;
      if (sel_vld) begin
        evt_chan_d = sel_idx;
        evt_rise_d = pend_rise_q[sel_idx];
      end
    end
  end

  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pend_q      <= '0;
      pend_rise_q <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      evt_rise_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      evt_rise_q  <= evt_rise_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_chan_o  = evt_chan_q;
  assign evt_rise_o  = evt_rise_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_plant_input_conditioner.sv
// Directed bench for plant_input_conditioner with an event scoreboard.
module tb_plant_input_conditioner;

  localparam int NCH   = 8;
  localparam int CNT_W = 16;
  localparam int D     = 4;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   sense = '0;
  logic             enable = 1'b1;
  logic             ready = 1'b1;
  logic             ovf_clr = 1'b0;
  logic [NCH-1:0]   level;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_chan;
  logic             evt_rise;
  logic             ovf;

  typedef struct packed {
    logic [IDX_W-1:0] chan;
    logic             rise;
  } evt_t;

  evt_t sb_q[$];
  evt_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  plant_input_conditioner #(
    .NCH          (NCH),
    .CNT_W        (CNT_W),
    .DEBOUNCE_CYC (D),
    .IDX_W        (IDX_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .sense_i     (sense),
    .enable_i    (enable),
    .level_o     (level),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_chan_o  (evt_chan),
    .evt_rise_o  (evt_rise),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input int ch, input logic r);
    evt_t e;
    e.chan = IDX_W'(ch);
    e.rise = r;
    sb_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_level"}, 32'(level), 0);
    check_val({tag, "_valid"}, 32'(evt_valid), 0);
    check_val({tag, "_chan"},  32'(evt_chan), 0);
    check_val({tag, "_rise"},  32'(evt_rise), 0);
    check_val({tag, "_ovf"},   32'(ovf), 0);
  endtask

  // Every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && evt_valid && ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_evt", 32'(evt_valid), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_chan", 32'(evt_chan), 32'(mon_e.chan));
        check_val("sb_rise", 32'(evt_rise), 32'(mon_e.rise));
      end
    end
  end

  initial begin
    #2;
    check_idle_outputs("reset");
    @(posedge clk);
    #3 rst = 1'b0;
    step(2);

    // Clean rise on ch2
    sense[2] = 1'b1;
    push_evt(2, 1'b1);
    step(D + 1);
    check_val("rise_level_early", 32'(level[2]), 0);
    step(1);
    check_val("rise_level", 32'(level[2]), 1);
    check_val("rise_valid_early", 32'(evt_valid), 0);
    step(1);
    check_val("rise_valid", 32'(evt_valid), 1);
    check_val("rise_chan", 32'(evt_chan), 2);
    check_val("rise_dir", 32'(evt_rise), 1);
    step(1);
    check_val("rise_valid_drop", 32'(evt_valid), 0);

    // Glitch of D-1 cycles on ch0
    sense[0] = 1'b1;
    step(D - 1);
    sense[0] = 1'b0;
    step(10);
    check_val("glitch_level", 32'(level[0]), 0);
    check_val("glitch_valid", 32'(evt_valid), 0);
    check_val("glitch_ovf", 32'(ovf), 0);

    // Simultaneous edges under backpressure
    ready = 1'b0;
    sense[5] = 1'b1;
    sense[1] = 1'b1;
    push_evt(1, 1'b1);
    push_evt(5, 1'b1);
    step(D + 2);
    check_val("simul_valid_early", 32'(evt_valid), 0);
    step(1);
    check_val("simul_valid", 32'(evt_valid), 1);
    check_val("simul_chan", 32'(evt_chan), 1);
    check_val("simul_dir", 32'(evt_rise), 1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_val("simul_hold_valid", 32'(evt_valid), 1);
      check_val("simul_hold_chan", 32'(evt_chan), 1);
    end
    ready = 1'b1;
    step(1);
    check_val("simul_second_valid", 32'(evt_valid), 1);
    check_val("simul_second_chan", 32'(evt_chan), 5);
    step(1);
    check_val("simul_drained", 32'(evt_valid), 0);

    // Overflow: ch3 rise then fall while the output is occupied by ch7
    ready = 1'b0;
    sense[7] = 1'b1;
    push_evt(7, 1'b1);
    push_evt(3, 1'b0);
    step(D + 3);
    check_val("ovf_blocker_valid", 32'(evt_valid), 1);
    check_val("ovf_blocker_chan", 32'(evt_chan), 7);
    sense[3] = 1'b1;
    step(D + 2);
    sense[3] = 1'b0;
    step(D + 1);
    check_val("ovf_not_yet", 32'(ovf), 0);
    step(1);
    check_val("ovf_set", 32'(ovf), 1);
    ready = 1'b1;
    step(1);
    check_val("ovf_evt_chan", 32'(evt_chan), 3);
    check_val("ovf_evt_dir", 32'(evt_rise), 0);
    step(1);
    check_val("ovf_drained", 32'(evt_valid), 0);
    check_val("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_val("ovf_cleared", 32'(ovf), 0);

    // Enable gating on ch4
    enable = 1'b0;
    sense[4] = 1'b1;
    step(D + 4);
    check_val("en_level", 32'(level[4]), 1);
    check_val("en_no_evt", 32'(evt_valid), 0);
    enable = 1'b1;
    step(5);
    check_val("en_no_stale", 32'(evt_valid), 0);
    check_val("en_sb_empty", 32'(sb_q.size()), 0);

    // Asynchronous reset while an event is held in the output
    ready = 1'b0;
    sense[6] = 1'b1;
    push_evt(6, 1'b1);
    step(D + 3);
    check_val("rst_pre_valid", 32'(evt_valid), 1);
    check_val("rst_pre_chan", 32'(evt_chan), 6);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sense = 8'h01;
    #1;
    check_idle_outputs("rst_async");
    sb_q.delete();
    step(2);
    #3 rst = 1'b0;
    ready = 1'b1;
    push_evt(0, 1'b1);
    step(D + 2);
    check_val("rst_level0", 32'(level), 1);
    check_val("rst_valid_early", 32'(evt_valid), 0);
    step(1);
    check_val("rst_evt_valid", 32'(evt_valid), 1);
    check_val("rst_evt_chan", 32'(evt_chan), 0);
    check_val("rst_evt_dir", 32'(evt_rise), 1);
    step(1);
    check_val("rst_evt_drop", 32'(evt_valid), 0);
    check_val("end_sb_empty", 32'(sb_q.size()), 0);
    check_val("end_ovf", 32'(ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
